// File: rtl/uart_rx_frame_checker.sv
// UART RX frame assembler: start, LSB-first data, optional parity, stop bits.
// Optional saturating error counters are enabled by defining UART_RX_ERR_CNT_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (strobe with i_bit=0)
// DATA   | shifting in DATA_WIDTH data bits, accumulating parity
// PARITY | checking the parity bit against the latched mode
// STOP   | sampling STOP_BITS stop bits, then delivering the word
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bit_valid,
    input  logic                  i_bit,
    input  logic [2:0]            i_parity_mode,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_parityerror,
    output logic                  o_frameerror
`ifdef UART_RX_ERR_CNT_EN
    ,
    input  logic                  i_cnt_clr,
    output logic [ERR_CNT_W-1:0]  o_parity_err_cnt,
    output logic [ERR_CNT_W-1:0]  o_frame_err_cnt
`endif
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("DATA_WIDTH must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("STOP_BITS must be 1 or 2");
        end
        if (ERR_CNT_W < 1) begin : g_bad_cnt
            $error("ERR_CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acc_q, acc_d;
    logic [2:0]              mode_q, mode_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    dv_d;
    logic                    pe_d;
    logic                    fe_d;
    logic                    par_en;

    // 101..111 behave as "none"
    assign par_en = (mode_q != 3'b000) && (mode_q <= 3'b100);
    assign o_busy = (state_q != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            acc_q         <= 1'b0;
            mode_q        <= 3'b000;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            o_data        <= '0;
            o_data_valid  <= 1'b0;
            o_parityerror <= 1'b0;
            o_frameerror  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mode_q        <= mode_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            o_data        <= data_d;
            o_data_valid  <= dv_d;
            o_parityerror <= pe_d;
            o_frameerror  <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = o_data;
        dv_d    = 1'b0;
        pe_d    = o_parityerror;
        fe_d    = o_frameerror;

        if (i_abort) begin
            // partial frame is dropped; delivered outputs stay as they were
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end else if (i_bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!i_bit) begin
                        state_d = DATA;
                        mode_d  = i_parity_mode;
                        acc_d   = 1'b0;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {i_bit, shift_q[DATA_WIDTH-1:1]};
                    acc_d   = acc_q ^ i_bit;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    case (mode_q)
                        3'b001:  perr_d = acc_q ^ i_bit;
                        3'b010:  perr_d = ~(acc_q ^ i_bit);
                        3'b011:  perr_d = ~i_bit;
                        3'b100:  perr_d = i_bit;
                        default: perr_d = 1'b0;
                    endcase
                    state_d = STOP;
                end
                STOP: begin
                    ferr_d = ferr_q | ~i_bit;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        pe_d    = par_en & perr_q;
                        fe_d    = ferr_q | ~i_bit;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_parity_err_cnt <= '0;
            o_frame_err_cnt  <= '0;
        end else if (i_cnt_clr) begin
            o_parity_err_cnt <= '0;
            o_frame_err_cnt  <= '0;
        end else if (o_data_valid) begin
            if (o_parityerror && (o_parity_err_cnt != '1))
                o_parity_err_cnt <= o_parity_err_cnt + ERR_CNT_W'(1);
            if (o_frameerror && (o_frame_err_cnt != '1))
                o_frame_err_cnt <= o_frame_err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench: dut0 is 8N/8P with one stop bit, dut1 has two stop bits.
// Counter checks run when UART_RX_ERR_CNT_EN is defined (dut0 uses 2-bit counters).
module tb_uart_rx_frame_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] bv;
    logic [1:0] bt;
    logic [1:0] ab;
    logic [2:0] md0, md1;
    logic       busy0, busy1, dv0, dv1, pe0, pe1, fe0, fe1;
    logic [7:0] data0, data1;
    int         checks;
    int         failures;
`ifdef UART_RX_ERR_CNT_EN
    logic       clr0, clr1;
    logic [1:0] pcnt0, fcnt0;
    logic [7:0] pcnt1, fcnt1;
`endif

    uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bv[0]), .i_bit(bt[0]),
        .i_parity_mode(md0), .i_abort(ab[0]), .o_busy(busy0), .o_data(data0),
        .o_data_valid(dv0), .o_parityerror(pe0), .o_frameerror(fe0)
`ifdef UART_RX_ERR_CNT_EN
        , .i_cnt_clr(clr0), .o_parity_err_cnt(pcnt0), .o_frame_err_cnt(fcnt0)
`endif
    );

    uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bv[1]), .i_bit(bt[1]),
        .i_parity_mode(md1), .i_abort(ab[1]), .o_busy(busy1), .o_data(data1),
        .o_data_valid(dv1), .o_parityerror(pe1), .o_frameerror(fe1)
`ifdef UART_RX_ERR_CNT_EN
        , .i_cnt_clr(clr1), .o_parity_err_cnt(pcnt1), .o_frame_err_cnt(fcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int sel, input logic b);
        @(negedge clk);
        bv[sel] = 1'b1;
        bt[sel] = b;
        @(negedge clk);
        bv[sel] = 1'b0;
    endtask

    // sends v[0] first, n bits, one strobe every other cycle
    task automatic send_bits(input int sel, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) strobe(sel, v[i]);
    endtask

    // returns at the negedge right after the final stop strobe: valid must be high now
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check({tag, "_dv"}, {31'd0, dv0}, 32'd1);
        check({tag, "_data"}, {24'd0, data0}, {24'd0, d});
        check({tag, "_pe"}, {31'd0, pe0}, {31'd0, pe});
        check({tag, "_fe"}, {31'd0, fe0}, {31'd0, fe});
        @(negedge clk);
        check({tag, "_dv_off"}, {31'd0, dv0}, 32'd0);
    endtask

    logic [15:0] f;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bv = '0;
        bt = '1;
        ab = '0;
        md0 = 3'b001;
        md1 = 3'b000;
`ifdef UART_RX_ERR_CNT_EN
        clr0 = 1'b0;
        clr1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_data", {24'd0, data0}, 32'd0);
        check("rst_dv", {31'd0, dv0}, 32'd0);
        check("rst_pe", {31'd0, pe0}, 32'd0);
        check("rst_fe", {31'd0, fe0}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        check("rst_pcnt", {30'd0, pcnt0}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // idle-high strobes are ignored
        send_bits(0, 16'hFFFF, 3);
        check("idle_busy", {31'd0, busy0}, 32'd0);
        check("idle_dv", {31'd0, dv0}, 32'd0);

        // even, 0xA5 (four ones) -> parity bit 0 is correct
        md0 = 3'b001;
        send_bits(0, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 10);
        check("even_ok_before_stop_dv", {31'd0, dv0}, 32'd0);
        check("even_ok_busy", {31'd0, busy0}, 32'd1);
        strobe(0, 1'b1);
        expect_frame("even_ok", 8'hA5, 1'b0, 1'b0);

        // even, 0xA5 with parity bit 1 -> parity error
        send_bits(0, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        expect_frame("even_bad", 8'hA5, 1'b1, 1'b0);

        // abort after 4 data bits, with a simultaneous strobe; flags of previous frame held
        send_bits(0, {11'd0, 4'b0110, 1'b0}, 5);
        @(negedge clk);
        ab[0] = 1'b1;
        bv[0] = 1'b1;
        bt[0] = 1'b0;
        @(negedge clk);
        ab[0] = 1'b0;
        bv[0] = 1'b0;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_dv", {31'd0, dv0}, 32'd0);
        check("abort_pe_held", {31'd0, pe0}, 32'd1);
        check("abort_data_held", {24'd0, data0}, 32'hA5);
        send_bits(0, {5'd0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        expect_frame("after_abort", 8'h55, 1'b0, 1'b0);

        // odd, 0x01 (one 1) -> parity bit 0 is correct
        md0 = 3'b010;
        send_bits(0, {5'd0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
        expect_frame("odd_ok", 8'h01, 1'b0, 1'b0);

        // mark: parity 1 correct; space: parity 1 wrong; stop 0 -> framing error
        md0 = 3'b011;
        send_bits(0, {5'd0, 1'b1, 1'b1, 8'h00, 1'b0}, 11);
        expect_frame("mark_ok", 8'h00, 1'b0, 1'b0);
        md0 = 3'b100;
        send_bits(0, {5'd0, 1'b0, 1'b1, 8'h81, 1'b0}, 11);
        expect_frame("space_bad_stop0", 8'h81, 1'b1, 1'b1);

        // reserved mode 111 acts as none: 10 strobes per frame
        md0 = 3'b111;
        send_bits(0, {6'd0, 1'b1, 8'h12, 1'b0}, 10);
        expect_frame("mode7_none", 8'h12, 1'b0, 1'b0);

        // mode change mid-frame is ignored: latched even, 0x0F, parity 0
        md0 = 3'b001;
        f = {5'd0, 1'b1, 1'b0, 8'h0F, 1'b0};
        send_bits(0, f, 4);
        md0 = 3'b010;
        send_bits(0, f >> 4, 7);
        expect_frame("mode_latched", 8'h0F, 1'b0, 1'b0);

        // reset mid-frame: everything back to reset values, no pulse
        md0 = 3'b001;
        send_bits(0, {11'd0, 4'b1010, 1'b0}, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_data", {24'd0, data0}, 32'd0);
        check("midrst_dv", {31'd0, dv0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(0, {5'd0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        expect_frame("after_rst", 8'h55, 1'b0, 1'b0);

        // dut1: none, two stops 1,0 -> exactly 11 strobes, framing error
        md1 = 3'b000;
        f = {5'd0, 1'b0, 1'b1, 8'h3C, 1'b0};
        send_bits(1, f, 10);
        check("two_stop_busy10", {31'd0, busy1}, 32'd1);
        check("two_stop_dv10", {31'd0, dv1}, 32'd0);
        send_bits(1, f >> 10, 1);
        check("two_stop_dv", {31'd0, dv1}, 32'd1);
        check("two_stop_data", {24'd0, data1}, 32'h3C);
        check("two_stop_fe", {31'd0, fe1}, 32'd1);
        check("two_stop_pe", {31'd0, pe1}, 32'd0);
        check("two_stop_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        check("two_stop_dv_off", {31'd0, dv1}, 32'd0);

`ifdef UART_RX_ERR_CNT_EN
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("cnt_cleared", {30'd0, pcnt0}, 32'd0);
        md0 = 3'b001;
        for (int k = 0; k < 5; k++) begin
            send_bits(0, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
            @(negedge clk);
        end
        check("pcnt_sat", {30'd0, pcnt0}, 32'd3);
        check("fcnt_zero", {30'd0, fcnt0}, 32'd0);
        send_bits(0, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        check("clr_cycle_dv", {31'd0, dv0}, 32'd1);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("pcnt_clr_prio", {30'd0, pcnt0}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Bit-serial successor to the combinational parity checker, sitting between the UART RX bit sampler and the RX FIFO. It consumes one sampled bit per strobe and assembles the frame: start, DATA_WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits. Parity is accumulated on the fly, with run-time even/odd/none/mark/space selection. Each frame ends with one data word plus parity and framing error flags.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
STOP_BITS, 1, stop bits checked per frame; legal 1 or 2.
ERR_CNT_W, 8, width of each saturating error counter (only with the optional feature).

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_bit_valid  input  1  one-cycle strobe: i_bit holds a mid-bit sample
i_bit  input  1  sampled serial line value
i_parity_mode  input  3  000 none, 001 even, 010 odd, 011 mark (parity=1), 100 space (parity=0); 101..111 treated as none
i_abort  input  1  synchronous frame abort (line break or RX disable)
o_busy  output  1  high while a frame is in progress (state != IDLE)
o_data  output  DATA_WIDTH  last assembled data word
o_data_valid  output  1  one-cycle pulse: frame complete
o_parityerror  output  1  parity error of last frame; valid with o_data_valid, held until the next pulse
o_frameerror  output  1  stop-bit error of last frame; same timing as o_parityerror

Behaviour:
- Reset (async assert, sync deassert upstream): FSM to IDLE; o_data=0, o_data_valid=0, o_parityerror=0, o_frameerror=0, o_busy=0; internal shift register, bit counter and parity accumulator are 0.
- All state advances only on cycles with i_bit_valid=1. Cycles without a strobe hold state.
- IDLE: strobe with i_bit=0 is a start bit. Latch i_parity_mode into mode_q, clear the accumulator and bit counter, go to DATA. Strobe with i_bit=1 is ignored.
- DATA: shift i_bit into the MSB of the shift register (right shift, LSB-first line order), XOR it into the accumulator, and increment the counter. After DATA_WIDTH bits, go to PARITY if mode_q is not none, else go to STOP.
- PARITY: compute the error flag for this frame:
  - even: error = acc ^ i_bit
  - odd: error = ~(acc ^ i_bit)
  - mark: error = ~i_bit
  - space: error = i_bit
  - Then go to STOP.
- STOP: each strobe checks i_bit. Any stop bit of 0 sets the framing flag. Sampling continues for all STOP_BITS bits; no early exit.
- After the last stop bit, in the same cycle as that strobe:
  - o_data takes the shift register.
  - o_parityerror and o_frameerror take the frame flags; o_parityerror is 0 if mode_q is none.
  - o_data_valid pulses for 1 cycle in the next cycle (registered output).
  - FSM returns to IDLE.
- Latency: o_data_valid rises exactly 1 clock after the final stop-bit strobe.
- The data word is delivered even when an error flag is set. The downstream FIFO decides whether to discard it.
- i_parity_mode changes mid-frame have no effect; only the value latched at the start bit is used.
- i_abort=1 in any state: return to IDLE and discard partial frame state. No o_data_valid, output flags unchanged. i_abort has priority over a simultaneous i_bit_valid.
- Reset mid-frame: same as the reset values above; no partial output.
- A new start bit is accepted on the first strobe after returning to IDLE. Back-to-back frames have no dead strobe.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined:
  - Adds inputs i_cnt_clr (1 bit, synchronous clear).
  - Adds outputs o_parity_err_cnt and o_frame_err_cnt (ERR_CNT_W bits each).
  - Each counter increments by 1 in the o_data_valid cycle when the matching flag is 1, and saturates at all-ones.
  - i_cnt_clr has priority over an increment.
  - Both counters reset to 0 on i_rst_n.
- Undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
- Even parity, DATA_WIDTH=8, STOP_BITS=1: send 0xA5 with parity bit 0 and stop 1 -> o_data=0xA5, o_data_valid pulse 1 cycle after the stop strobe, both error flags 0.
- Even parity, send 0xA5 with parity bit 1 -> o_data=0xA5, o_parityerror=1, o_frameerror=0. Then odd parity, 0x01 with parity 0 -> both flags 0.
- Mode none, STOP_BITS=2: send 0x3C with stop bits 1,0 -> o_data=0x3C, o_frameerror=1, o_parityerror=0. No parity slot consumed: exactly 11 strobes per frame.
- Switch i_parity_mode from even to odd after the 3rd data bit of 0x0F (parity bit 0) -> no parity error, because the latched even mode is used.
- Assert i_abort after 4 data bits (also a separate frame with reset mid-frame), then send 0x55 cleanly -> no pulse for the aborted frame, next frame gives o_data=0x55 and flags 0. Idle-high strobes in IDLE produce no activity.
- With UART_RX_ERR_CNT_EN and ERR_CNT_W=2: 5 frames with bad parity -> o_parity_err_cnt=3 (saturated). Pulse i_cnt_clr in the same cycle as a 6th error -> counter=0.
